// File: rtl/matrix_merge_64_row.sv
// Purpose : merges four 16x16 PE result tiles into one 16x64 row-major matrix.
// Latency : 4th tile accepted at edge N -> Matrix_out/out_valid updated after edge N.
// Backpr. : output is double-buffered; intake stalls (tile_ready=0) only when a
//           completed matrix is waiting behind an unconsumed one.
//
// Ports:
//   clk, rst     - rising-edge clock, synchronous active-low reset
//   tile_in      - one 16x16 tile, row r at [4095-256r -: 256], elements MSB-first
//   tile_valid / tile_ready - tile intake handshake
//   Matrix_out   - merged 16x64 matrix, row r at [16383-1024r -: 1024]
//   out_valid / out_ready   - merged matrix handshake
//   tile_cnt     - tiles collected so far for the matrix under construction
// Optional feature macro: MATRIX_MERGE_IDX_CHK_EN
//   adds tile_idx[1:0] (position claimed by the sender) and idx_err[0:0]
//   (one-cycle pulse when an accepted tile is out of order; that tile is dropped).
module matrix_merge_64_row (
    input  logic             clk,
    input  logic             rst,
    input  logic [4095:0]    tile_in,
    input  logic             tile_valid,
    output logic             tile_ready,
    output logic [16383:0]   Matrix_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       tile_cnt
`ifdef MATRIX_MERGE_IDX_CHK_EN
    ,
    input  logic [1:0]       tile_idx,
    output logic [0:0]       idx_err
`endif
);

    localparam int DW     = 16;
    localparam int ROWS   = 16;
    localparam int TCOLS  = 16;
    localparam int NTILES = 4;
    localparam int TROW_W = DW * TCOLS;        // 256 bits per tile row
    localparam int MROW_W = TROW_W * NTILES;   // 1024 bits per merged row
    localparam int TILE_W = TROW_W * ROWS;     // 4096
    localparam int MAT_W  = MROW_W * ROWS;     // 16384

    typedef enum logic {ST_FILL, ST_HOLD} state_t;

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [MAT_W-1:0]    buf_q, buf_d;
    logic [MAT_W-1:0]    mat_q, mat_d;
    logic                ov_q, ov_d;
    logic                tile_ready_q, tile_ready_d;
    logic                err_q, err_d;
    logic                accept;
    logic                idx_ok;

    assign accept = tile_valid && tile_ready_q;

`ifdef MATRIX_MERGE_IDX_CHK_EN
    assign idx_ok  = (tile_idx == cnt_q);
    assign idx_err = err_q;
`else
    assign idx_ok  = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        mat_d        = mat_q;
        ov_d         = ov_q;
        err_d        = 1'b0;

        // A consumed matrix clears out_valid unless a new one lands this edge.
        if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end

        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    if (!idx_ok) begin
                        // Out-of-order tile is swallowed; count does not move.
                        err_d = 1'b1;
                    end else begin
                        for (int r = 0; r < ROWS; r++) begin
                            buf_d[MAT_W-1 - MROW_W*r - TROW_W*int'(cnt_q) -: TROW_W] =
                                tile_in[TILE_W-1 - TROW_W*r -: TROW_W];
                        end
                        cnt_d = cnt_q + 2'd1;   // wraps 3 -> 0
                        if (cnt_q == 2'd3) begin
                            if (!ov_q || out_ready) begin
                                // Bypass the buffer so the 4th tile shows up immediately.
                                mat_d = buf_d;
                                ov_d  = 1'b1;
                            end else begin
                                state_d = ST_HOLD;
                            end
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (ov_q && out_ready) begin
                    mat_d   = buf_q;
                    ov_d    = 1'b1;
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase

        tile_ready_d = (state_d == ST_FILL);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_FILL;
            cnt_q        <= 2'd0;
            buf_q        <= '0;
            mat_q        <= '0;
            ov_q         <= 1'b0;
            tile_ready_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            mat_q        <= mat_d;
            ov_q         <= ov_d;
            tile_ready_q <= tile_ready_d;
            err_q        <= err_d;
        end
    end

    assign tile_ready = tile_ready_q;
    assign Matrix_out = mat_q;
    assign out_valid  = ov_q;
    assign tile_cnt   = cnt_q;

`ifndef MATRIX_MERGE_IDX_CHK_EN
    // err_q is only observable when the index check is built in.
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_matrix_merge_64_row.sv
module tb_matrix_merge_64_row;

    logic             clk = 1'b0;
    logic             rst;
    logic [4095:0]    tile_in;
    logic             tile_valid;
    logic             tile_ready;
    logic [16383:0]   Matrix_out;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       tile_cnt;
`ifdef MATRIX_MERGE_IDX_CHK_EN
    logic [1:0]       tile_idx;
    logic [0:0]       idx_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    matrix_merge_64_row dut (
        .clk        (clk),
        .rst        (rst),
        .tile_in    (tile_in),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .Matrix_out (Matrix_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .tile_cnt   (tile_cnt)
`ifdef MATRIX_MERGE_IDX_CHK_EN
        ,
        .tile_idx   (tile_idx),
        .idx_err    (idx_err)
`endif
    );

    // Advance one clock, then sample 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-matrix compare; on failure report the first differing element only.
    task automatic chk_mat(input string tag, input logic [16383:0] obs, input logic [16383:0] exp);
        int fi;
        fi = -1;
        total++;
        for (int i = 0; i < 1024; i++) begin
            if (fi < 0 && obs[16383-16*i -: 16] !== exp[16383-16*i -: 16]) fi = i;
        end
        assert (obs === exp) else begin
            bad++;
            if (fi < 0) fi = 0;
            $error("FAIL %s row=%0d col=%0d observed=%h expected=%h", tag, fi / 64, fi % 64,
                   obs[16383-16*fi -: 16], exp[16383-16*fi -: 16]);
        end
    endtask

    function automatic logic [4095:0] fill_tile(input logic [15:0] v);
        logic [255:0] row;
        row = {16{v}};
        return {16{row}};
    endfunction

    // Expected merged matrix when tile k is filled with value v[k].
    function automatic logic [16383:0] fill_mat(input logic [15:0] v0, input logic [15:0] v1,
                                                input logic [15:0] v2, input logic [15:0] v3);
        logic [1023:0] row;
        row = {{16{v0}}, {16{v1}}, {16{v2}}, {16{v3}}};
        return {16{row}};
    endfunction

    function automatic logic [4095:0] pat_tile(input int k);
        logic [4095:0] t;
        logic [15:0]   e;
        t = '0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                e = 16'(k*256 + r*16 + c);
                t[4095-256*r-16*c -: 16] = e;
            end
        end
        return t;
    endfunction

    task automatic send_fill(input logic [15:0] v);
        tile_in    = fill_tile(v);
        tile_valid = 1'b1;
        step();
    endtask

    initial begin
        logic [16383:0] mat_a;
        logic [16383:0] mat_b;
        logic [15:0]    e;
        int             perr;

        // 1. reset with tile_valid asserted
        rst        = 1'b0;
        tile_in    = fill_tile(16'h9999);
        tile_valid = 1'b1;
        out_ready  = 1'b1;
`ifdef MATRIX_MERGE_IDX_CHK_EN
        tile_idx   = 2'd0;
`endif
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk_mat("rst_matrix", Matrix_out, '0);
        chk("rst_tile_cnt", 32'(tile_cnt), 32'd0);
        rst        = 1'b1;
        tile_valid = 1'b0;
        step();
        chk("post_rst_cnt", 32'(tile_cnt), 32'd0);
        chk("post_rst_ready", 32'(tile_ready), 32'd1);

        // 2. constant-filled tiles back-to-back
        send_fill(16'h0000);
        chk("fill_cnt1", 32'(tile_cnt), 32'd1);
        send_fill(16'h1111);
        send_fill(16'h2222);
        chk("fill_cnt3", 32'(tile_cnt), 32'd3);
        chk("fill_ov_before", 32'(out_valid), 32'd0);
        send_fill(16'h3333);
        chk("fill_ov", 32'(out_valid), 32'd1);
        chk("fill_cnt_wrap", 32'(tile_cnt), 32'd0);
        chk_mat("fill_matrix", Matrix_out, fill_mat(16'h0000, 16'h1111, 16'h2222, 16'h3333));
        tile_valid = 1'b0;
        step();
        chk("drain_ov", 32'(out_valid), 32'd0);
        chk_mat("drain_hold", Matrix_out, fill_mat(16'h0000, 16'h1111, 16'h2222, 16'h3333));

        // 3. position-coded pattern, exact inverse of the splitter
        for (int k = 0; k < 4; k++) begin
            tile_in    = pat_tile(k);
            tile_valid = 1'b1;
            step();
        end
        tile_valid = 1'b0;
        chk("pat_ov", 32'(out_valid), 32'd1);
        perr = 0;
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++) begin
                    e = Matrix_out[16383-1024*r-16*(16*k+c) -: 16];
                    if (e !== 16'(k*256 + r*16 + c)) perr++;
                end
        chk("pat_elem_errors", 32'(perr), 32'd0);
        step();

        // 4. backpressure: 8 tiles with out_ready low
        out_ready = 1'b0;
        mat_a = fill_mat(16'hA000, 16'hA001, 16'hA002, 16'hA003);
        mat_b = fill_mat(16'hB000, 16'hB001, 16'hB002, 16'hB003);
        for (int k = 0; k < 4; k++) send_fill(16'hA000 + 16'(k));
        chk("bp_ov_a", 32'(out_valid), 32'd1);
        chk_mat("bp_mat_a", Matrix_out, mat_a);
        chk("bp_ready_a", 32'(tile_ready), 32'd1);
        for (int k = 0; k < 4; k++) send_fill(16'hB000 + 16'(k));
        chk("bp_hold_ready", 32'(tile_ready), 32'd0);
        chk_mat("bp_stable_a", Matrix_out, mat_a);
        tile_in = fill_tile(16'hDEAD);   // must be ignored while stalled
        step();
        chk("bp_still_hold", 32'(tile_ready), 32'd0);
        chk_mat("bp_still_a", Matrix_out, mat_a);
        tile_valid = 1'b0;
        out_ready  = 1'b1;
        step();
        chk_mat("bp_mat_b", Matrix_out, mat_b);
        chk("bp_ov_b", 32'(out_valid), 32'd1);
        chk("bp_ready_b", 32'(tile_ready), 32'd1);
        chk("bp_cnt_b", 32'(tile_cnt), 32'd0);
        step();
        chk("bp_drain", 32'(out_valid), 32'd0);

        // simultaneous 4th accept and drain
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_fill(16'hC000 + 16'(k));
        for (int k = 0; k < 3; k++) send_fill(16'hD000 + 16'(k));
        chk_mat("sim_c_held", Matrix_out, fill_mat(16'hC000, 16'hC001, 16'hC002, 16'hC003));
        out_ready = 1'b1;
        send_fill(16'hD003);
        tile_valid = 1'b0;
        chk_mat("sim_mat_d", Matrix_out, fill_mat(16'hD000, 16'hD001, 16'hD002, 16'hD003));
        chk("sim_ov", 32'(out_valid), 32'd1);
        chk("sim_ready", 32'(tile_ready), 32'd1);
        step();

        // 5. reset mid-fill discards partial tiles
        send_fill(16'h5555);
        send_fill(16'h5555);
        chk("mid_cnt2", 32'(tile_cnt), 32'd2);
        tile_valid = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_rst_cnt", 32'(tile_cnt), 32'd0);
        chk_mat("mid_rst_mat", Matrix_out, '0);
        for (int k = 0; k < 4; k++) send_fill(16'h7FFF);
        tile_valid = 1'b0;
        chk("max_ov", 32'(out_valid), 32'd1);
        chk_mat("max_mat", Matrix_out, fill_mat(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF));
        step();

`ifdef MATRIX_MERGE_IDX_CHK_EN
        // 6. index check: 0,2,1,2,3
        chk("idx_err_idle", 32'(idx_err), 32'd0);
        tile_idx = 2'd0; send_fill(16'h0E00);
        chk("idx0_err", 32'(idx_err), 32'd0);
        tile_idx = 2'd2; send_fill(16'hBAD0);
        chk("idx_bad_err", 32'(idx_err), 32'd1);
        chk("idx_bad_cnt", 32'(tile_cnt), 32'd1);
        tile_idx = 2'd1; send_fill(16'h0E01);
        chk("idx_err_pulse", 32'(idx_err), 32'd0);
        chk("idx1_cnt", 32'(tile_cnt), 32'd2);
        tile_idx = 2'd2; send_fill(16'h0E02);
        tile_idx = 2'd3; send_fill(16'h0E03);
        tile_valid = 1'b0;
        chk("idx_ov", 32'(out_valid), 32'd1);
        chk_mat("idx_mat", Matrix_out, fill_mat(16'h0E00, 16'h0E01, 16'h0E02, 16'h0E03));
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
